cache_arbiter: RTL
==================

# cache_arbiter

Two-port arbiter that shares one blocking cache between an instruction-fetch requester (port 0) and a data requester (port 1). It sits between the CPU pipeline and the cache's single `addr`/`rd_req`/`wr_req`/`miss` interface, and serialises accesses one at a time. Each access is held on the cache until the cache's `miss` deasserts, then acknowledged to the owning port. It also keeps saturating hit/miss counters for performance measurement.

## Interface
- `ADDR_W`, 32, byte address width (matches the cache `addr`).
- `DATA_W`, 32, word width.
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset. The same net resets the cache.
- `p0_req`, `p1_req`  in  1  request; held high until `pX_ack`.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read; stable while req is high.
- `p0_addr`, `p1_addr`  in  ADDR_W  access address; stable while req is high.
- `p0_wdata`, `p1_wdata`  in  DATA_W  write data; stable while req is high.
- `p0_ack`, `p1_ack`  out  1  one-cycle completion pulse.
- `p0_rdata`, `p1_rdata`  out  DATA_W  equal to `cache_rd_data`; meaningful only while that port's ack is high after a read.
- `cache_addr`  out  ADDR_W  address to the cache.
- `cache_rd_req`, `cache_wr_req`  out  1  cache request strobes.
- `cache_wr_data`  out  DATA_W  write data to the cache.
- `cache_miss`  in  1  cache miss/busy signal (combinational in the cache).
- `cache_rd_data`  in  DATA_W  cache read data; registered in the cache one edge after a hit.
- `hit_cnt`, `miss_cnt`  out  32  saturating access counters.

## Operation
- State machine `ARB_IDLE` → `ARB_BUSY` → `ARB_RESP` → `ARB_IDLE`.
- **ARB_IDLE**
  - If any req is high, pick a winner and register `owner`.
  - Load `cache_addr`, `cache_wr_data` and `is_wr` from the winner's inputs, then go to ARB_BUSY.
  - With no request, stay in ARB_IDLE; cache strobes stay 0.
- **ARB_BUSY**
  - `cache_rd_req = ~is_wr`, `cache_wr_req = is_wr`. The two are never high together.
  - Address and data are held constant.
  - Stay here while `cache_miss = 1`.
  - On the first edge with `cache_miss = 0` the cache performs the access; go to ARB_RESP.
- **ARB_RESP**
  - `pX_ack = 1` for `owner` only; both strobes are 0.
  - Requests are ignored in this state. Go to ARB_IDLE.
- Requests arriving while in ARB_BUSY or ARB_RESP wait; a waiting req is sampled in the next ARB_IDLE.
- **Selection**
  - Both requesting: the port not granted last wins.
  - Only one requesting: that port wins.
  - After reset the last-grant pointer = 1, so port 0 wins the first tie.
- **Counters**
  - Each counter saturates at 32'hFFFF_FFFF.
  - On the first ARB_BUSY cycle of an access, the access increments `hit_cnt` if `cache_miss = 0`, otherwise `miss_cnt`.
  - Exactly one counter increment per access.

## Timing
- Reset values:
  - State = ARB_IDLE.
  - All strobes = 0, both acks = 0.
  - `cache_addr`, `cache_wr_data`, `owner`, `is_wr` = 0.
  - Both counters = 0; pointer = 1.
  - `pX_rdata` follows `cache_rd_data`, which the cache resets to 0.
- Hit latency: req seen in cycle 0 (ARB_IDLE), cache strobe in cycle 1, ack (and read data) in cycle 2.
- Miss latency: the ack comes in the cycle after the first cycle in ARB_BUSY with `cache_miss = 0`.
- Back-to-back: minimum spacing is 3 cycles per access.
  - The requester may present its next request on the edge that ends its ack cycle.
  - That request is arbitrated in the following ARB_IDLE.
- Reset asserted mid-access:
  - Return to ARB_IDLE immediately; no ack is issued for the aborted access.
  - Requesters re-issue.
- Requester dropping req before ack is illegal; behaviour is unspecified. The verification bench asserts against it.

## Configuration
- Macro `CACHE_ARB_RR_EN`.
- Defined: round-robin selection as described above.
- Undefined: fixed priority, port 1 (data) always wins ties.
  - The last-grant pointer is not implemented.
  - Port 0 can starve while port 1 streams requests.

## Structure
- Package `cache_arb_pkg`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t`.
  - `localparam PORT_IF = 0, PORT_MEM = 1`.
  - `localparam CNT_MAX = 32'hFFFF_FFFF`.
- One sub-module `sat_counter` (32-bit, inputs `clk`, `rst`, `inc`), instantiated twice for `hit_cnt`/`miss_cnt`.

## Test plan
- **Read hit**, cache pre-filled: `p1_req`, read, addr 0x40 → `cache_rd_req` in cycle 1, `p1_ack` in cycle 2 with `p1_rdata` = stored word; `hit_cnt` = 1.
- **Write miss, clean victim**: `p1_req`, write, 0x200, data 0xDEADBEEF → strobe held through all miss cycles; ack one cycle after miss falls; `miss_cnt` = 1; a following read of 0x200 returns 0xDEADBEEF.
- **Simultaneous requests, RR build**: both ports request every cycle → grants alternate 0,1,0,1; with the macro undefined, grants are 1,1,1 and `p0_ack` never fires.
- **Reset during ARB_BUSY** on a miss → next cycle all strobes and acks = 0, counters = 0; the re-issued request completes normally.
- **Counter saturation**: force `hit_cnt` to 32'hFFFF_FFFE, then issue 3 hits → reads 32'hFFFF_FFFF and stays there.
- **Back-to-back**: port 0 issues a new read on the edge after its ack → second ack exactly 3 cycles after the first on a hit.

Source files
------------

// File: rtl/cache_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_arb_pkg
// Description : Shared types and constants for the two-port cache arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    localparam int PORT_IF  = 0;
    localparam int PORT_MEM = 1;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

endpackage : cache_arb_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : 32-bit event counter that sticks at CNT_MAX instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import cache_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] o_count
);

    logic [31:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 32'd0;
        end else if (inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter
// Description : Serialises an instruction port and a data port onto one
//               blocking cache, with saturating hit/miss counters.
//               CACHE_ARB_RR_EN defined   -> round-robin on ties.
//               CACHE_ARB_RR_EN undefined -> port 1 always wins ties.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_rd_req,
    output logic              cache_wr_req,
    output logic [DATA_W-1:0] cache_wr_data,
    input  logic              cache_miss,
    input  logic [DATA_W-1:0] cache_rd_data,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              r_owner;
    logic              r_is_wr;
    logic              r_first_busy;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_any_req;
    logic              w_grant;
    logic              w_winner;
    logic              w_hit_inc;
    logic              w_miss_inc;

    assign w_any_req = p0_req | p1_req;
    assign w_grant   = (r_state == ARB_IDLE) && w_any_req;

`ifdef CACHE_ARB_RR_EN
    logic r_last;

    // On a tie the port that did not win last time is served.
    always_comb begin
        w_winner = 1'(PORT_IF);
        if (p0_req && p1_req) begin
            w_winner = ~r_last;
        end else if (p1_req) begin
            w_winner = 1'(PORT_MEM);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_winner;
        end
    end
`else
    assign w_winner = p1_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        cache_rd_req = 1'b0;
        cache_wr_req = 1'b0;
        p0_ack       = 1'b0;
        p1_ack       = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_any_req) begin
                    w_state_next = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                cache_rd_req = ~r_is_wr;
                cache_wr_req = r_is_wr;
                if (!cache_miss) begin
                    w_state_next = ARB_RESP;
                end
            end
            ARB_RESP: begin
                p0_ack       = (r_owner == 1'(PORT_IF));
                p1_ack       = (r_owner == 1'(PORT_MEM));
                w_state_next = ARB_IDLE;
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    // Access attributes are captured once at grant and held for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= 1'b0;
            r_is_wr      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_first_busy <= 1'b0;
        end else begin
            r_first_busy <= w_grant;
            if (w_grant) begin
                r_owner <= w_winner;
                r_is_wr <= w_winner ? p1_we    : p0_we;
                r_addr  <= w_winner ? p1_addr  : p0_addr;
                r_wdata <= w_winner ? p1_wdata : p0_wdata;
            end
        end
    end

    assign cache_addr    = r_addr;
    assign cache_wr_data = r_wdata;
    assign p0_rdata      = cache_rd_data;
    assign p1_rdata      = cache_rd_data;

    // Hit or miss is judged only on the first busy cycle, so each access counts once.
    assign w_hit_inc  = (r_state == ARB_BUSY) && r_first_busy && !cache_miss;
    assign w_miss_inc = (r_state == ARB_BUSY) && r_first_busy &&  cache_miss;

    sat_counter u_hit_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (w_hit_inc),
        .o_count (hit_cnt)
    );

    sat_counter u_miss_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (w_miss_inc),
        .o_count (miss_cnt)
    );

endmodule : cache_arbiter
`default_nettype wire
